// File: rtl/controle_teclado.sv
// controle_teclado: keypad entry controller for an MM:SS timer.
//   Debounces a 10-line active-high keypad, strobes an external priority
//   encoder for one cycle and shifts the returned BCD digit into a
//   four-digit MM:SS register (entered right to left).
// Parameters:
//   DEBOUNCE      consecutive stable cycles before a key is accepted (1..15)
// Configuration macro:
//   CONTROLE_TECLADO_VALIDA_SEGUNDOS_EN  when defined, a capture that would
//                 make seg_dez exceed 5 is rejected with an erro pulse.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   teclado[9:0]  raw key lines, bit k = digit k
//   BCD[3:0]      digit from the external encoder
//   limpar        synchronous clear of the entered value
//   travar        entry lock (timer running)
//   enablen_cod   encoder enable, active-low, low only in the capture cycle
//   min_dez, min_uni, seg_dez, seg_uni  entered digits
//   novo_digito   one-cycle pulse when a digit is stored
//   erro          one-cycle pulse when a capture is rejected
module controle_teclado #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] teclado,
    input  logic [3:0] BCD,
    input  logic       limpar,
    input  logic       travar,
    output logic       enablen_cod,
    output logic [3:0] min_dez,
    output logic [3:0] min_uni,
    output logic [3:0] seg_dez,
    output logic [3:0] seg_uni,
    output logic       novo_digito,
    output logic       erro
);

    localparam int unsigned DEB_W   = 5;
    localparam int unsigned TEC_W   = 10;
    localparam int unsigned NDIG_W  = 3;
    localparam logic [DEB_W-1:0]  DEB_LIM = DEB_W'(DEBOUNCE);
    localparam logic [NDIG_W-1:0] MAX_DIG = NDIG_W'(4);
    localparam bit CAPTURA_DIRETA = (DEBOUNCE <= 1);

    typedef enum logic [1:0] {
        OCIOSO,
        ESTAVEL,
        CAPTURA,
        ESPERA_SOLTA
    } estado_t;

    estado_t            estado;
    logic [TEC_W-1:0]   padrao;
    logic [3:0]         cont_deb;
    logic [NDIG_W-1:0]  cont_dig;
    logic               liberado;

    logic               solto;
    logic               valido;
    logic               rejeita_seg;
    logic [DEB_W-1:0]   cont_deb_prox;

    // Key decode: exactly one line high is a valid key
    assign solto         = (teclado == '0);
    assign valido        = !solto && ((teclado & (teclado - TEC_W'(1))) == '0);
    assign cont_deb_prox = {1'b0, cont_deb} + DEB_W'(1);

`ifdef CONTROLE_TECLADO_VALIDA_SEGUNDOS_EN
    // Shifting seg_uni into seg_dez must keep tens of seconds within 0..5
    assign rejeita_seg = (cont_dig >= NDIG_W'(1)) && (seg_uni > 4'd5);
`else
    assign rejeita_seg = 1'b0;
`endif

    // Entry FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            estado      <= OCIOSO;
            padrao      <= '0;
            cont_deb    <= '0;
            cont_dig    <= '0;
            liberado    <= 1'b0;
            enablen_cod <= 1'b1;
            novo_digito <= 1'b0;
            erro        <= 1'b0;
            min_dez     <= '0;
            min_uni     <= '0;
            seg_dez     <= '0;
            seg_uni     <= '0;
        end else begin
            novo_digito <= 1'b0;
            erro        <= 1'b0;
            enablen_cod <= 1'b1;

            // A key held through reset must be released before it can count
            if (solto) begin
                liberado <= 1'b1;
            end

            if (limpar) begin
                min_dez  <= '0;
                min_uni  <= '0;
                seg_dez  <= '0;
                seg_uni  <= '0;
                cont_dig <= '0;
                cont_deb <= '0;
                estado   <= solto ? OCIOSO : ESPERA_SOLTA;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (!solto) begin
                            if (valido && !travar && liberado) begin
                                padrao   <= teclado;
                                cont_deb <= 4'd1;
                                if (CAPTURA_DIRETA) begin
                                    estado      <= CAPTURA;
                                    enablen_cod <= 1'b0;
                                end else begin
                                    estado <= ESTAVEL;
                                end
                            end else begin
                                estado <= ESPERA_SOLTA;
                            end
                        end
                    end
                    ESTAVEL: begin
                        if (travar) begin
                            estado <= ESPERA_SOLTA;
                        end else if (teclado != padrao) begin
                            estado <= OCIOSO;
                        end else if (cont_deb_prox >= DEB_LIM) begin
                            estado      <= CAPTURA;
                            enablen_cod <= 1'b0;
                        end else begin
                            cont_deb <= cont_deb_prox[3:0];
                        end
                    end
                    CAPTURA: begin
                        estado <= ESPERA_SOLTA;
                        if ((cont_dig == MAX_DIG) || rejeita_seg) begin
                            erro <= 1'b1;
                        end else begin
                            min_dez     <= min_uni;
                            min_uni     <= seg_dez;
                            seg_dez     <= seg_uni;
                            seg_uni     <= BCD;
                            cont_dig    <= cont_dig + NDIG_W'(1);
                            novo_digito <= 1'b1;
                        end
                    end
                    ESPERA_SOLTA: begin
                        if (solto) begin
                            estado <= OCIOSO;
                        end
                    end
                    default: begin
                        estado <= OCIOSO;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/controle_teclado.md
CONTROLE_TECLADO -- requirements
Module: controle_teclado

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: consecutive stable cycles required before a key is accepted (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port teclado  input  10  raw key lines, active-high, bit k = digit k.
REQ-005 SHALL have port BCD  input  4  digit returned by the external priority encoder.
REQ-006 SHALL have port limpar  input  1  synchronous clear of the entered value, active-high.
REQ-007 SHALL have port travar  input  1  entry lock (timer running), active-high.
REQ-008 SHALL have port enablen_cod  output  1  drives the encoder enablen, active-low.
REQ-009 SHALL have port min_dez, min_uni, seg_dez, seg_uni  output  4 each  entered MM:SS digits, BCD.
REQ-010 SHALL have port novo_digito  output  1  one-cycle pulse when a digit is stored.
REQ-011 SHALL have port erro  output  1  one-cycle pulse when a key is rejected.

Function
REQ-012 SHALL implement FSM states OCIOSO, ESTAVEL, CAPTURA, ESPERA_SOLTA.
REQ-013 Valid key = teclado exactly one-hot; zero bits = no key; two or more bits = invalid.
REQ-014 OCIOSO: valid key and travar=0 -> ESTAVEL with counter=1 and pattern registered; invalid pattern, or any key with travar=1 -> ESPERA_SOLTA.
REQ-015 ESTAVEL: pattern unchanged -> counter+1; counter reaching DEBOUNCE -> CAPTURA; pattern change or all released -> OCIOSO; travar rising -> ESPERA_SOLTA.
REQ-016 CAPTURA SHALL last exactly one cycle with enablen_cod=0; enablen_cod SHALL be 1 in every other state.
REQ-017 On the edge leaving CAPTURA the block SHALL shift digits left (min_dez<=min_uni, min_uni<=seg_dez, seg_dez<=seg_uni, seg_uni<=BCD) and pulse novo_digito in the following cycle; next state ESPERA_SOLTA.
REQ-018 A digit counter (0..4) SHALL increment per stored digit; with counter=4 a capture SHALL not shift, SHALL pulse erro instead.
REQ-019 ESPERA_SOLTA -> OCIOSO only after teclado=0 for one full cycle; no capture while held.
REQ-020 Latency: key stable from cycle t -> novo_digito high at cycle t+DEBOUNCE+1.
REQ-021 limpar=1 SHALL zero all digits and counter next edge, override any same-cycle capture (no novo_digito), go to ESPERA_SOLTA if any key high else OCIOSO.
REQ-022 novo_digito and erro SHALL never be high in the same cycle.

Reset
REQ-023 resetn=0 at an edge SHALL force state OCIOSO, all digits 0, counters 0, enablen_cod=1, novo_digito=0, erro=0, regardless of other inputs, including mid-CAPTURA.

Configuration
REQ-024 Macro CONTROLE_TECLADO_VALIDA_SEGUNDOS_EN defined: a capture whose shift would make seg_dez > 5 (current seg_uni > 5 with counter >= 1) SHALL be rejected -- no shift, counter unchanged, erro pulsed.
REQ-025 Macro undefined: no seconds range check; all captures accepted per REQ-017/018.

Verification
REQ-026 Reset, press teclado=0x004 for DEBOUNCE cycles, release -> enablen_cod low one cycle, seg_uni=2, novo_digito pulse at t+5, other digits 0.
REQ-027 Keys 1,2,3,0 each held 6 cycles, released 2 -> min_dez=1, min_uni=2, seg_dez=3, seg_uni=0; fifth key 7 -> erro pulse, digits unchanged.
REQ-028 Key 5 held 2 cycles then released (DEBOUNCE=4) -> no novo_digito, enablen_cod never low; teclado=0x003 held 10 cycles -> no capture.
REQ-029 limpar asserted in the CAPTURA cycle -> all digits 0, no novo_digito; travar=1 with key 8 held 20 cycles -> no capture.
REQ-030 With CONTROLE_TECLADO_VALIDA_SEGUNDOS_EN: enter 7, then 1 -> erro pulse, seg_uni stays 7; without macro -> seg_dez=7, seg_uni=1.
REQ-031 resetn low during ESTAVEL with digits 1,2 stored -> next cycle all outputs at reset values, key still held does not capture until released and re-pressed.
